// File: rtl/ser_reg_file_p.sv
// ser_reg_file_p: serial-access register file with per-register address,
// reset value and read-only attribute. A host starts a transaction with a
// one-cycle WR_EN or RD_EN strobe, then shifts address (and write data)
// MSB first on DIN. Writes are committed atomically from a shadow register.
// Read data is shifted out MSB first on DOUT.
//
// Ports:
//   CLK    clock, all logic on the rising edge
//   RST    synchronous reset, active-high
//   WR_EN  write-transaction start strobe (sampled in IDLE only)
//   RD_EN  read-transaction start strobe (sampled in IDLE only)
//   DIN    serial address / write-data input, MSB first
//   DOUT   serial read-data output, MSB first
//   BUSY   high while a transaction is in progress
//   ACK    one-cycle pulse when a transaction finishes
//   ERR    one-cycle pulse: bad address / RO write (with ACK), or double strobe
//   REGS   parallel view of all registers, reg i in slice i
module ser_reg_file_p #(
    parameter int unsigned N_REG      = 5,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter logic [N_REG*ADDR_WIDTH-1:0] REG_ADDRS = {8'h55, 8'h06, 8'hA1, 8'h78, 8'h34},
    parameter logic [N_REG*DATA_WIDTH-1:0] RST_VALS  = {8'h33, 8'h00, 8'h00, 8'h00, 8'h00},
    parameter logic [N_REG-1:0]            RO_MASK   = 5'b10000
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        WR_EN,
    input  logic                        RD_EN,
    input  logic                        DIN,
    output logic                        DOUT,
    output logic                        BUSY,
    output logic                        ACK,
    output logic                        ERR,
    output logic [N_REG*DATA_WIDTH-1:0] REGS
);

    localparam int unsigned MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int unsigned CNT_W = $clog2(MAX_W) + 1;
    localparam int unsigned IDX_W = (N_REG > 1) ? $clog2(N_REG) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        WDATA = 2'd2,
        RDATA = 2'd3
    } state_t;

    state_t              state;
    logic                op_wr;
    logic [CNT_W-1:0]    cnt;
    logic [ADDR_WIDTH-2:0] addr_q;
    logic [DATA_WIDTH-2:0] shd_q;
    // Remaining read bits; the bit currently on DOUT is held in DOUT itself.
    logic [DATA_WIDTH-2:0] sh_q;
    logic                hit_q;
    logic                ro_q;
    logic [IDX_W-1:0]    idx_q;

    logic [ADDR_WIDTH-1:0] addr_full_c;
    logic [DATA_WIDTH-1:0] wdata_full_c;
    logic                  dec_hit_c;
    logic                  dec_ro_c;
    logic [IDX_W-1:0]      dec_idx_c;
    logic [DATA_WIDTH-1:0] rd_data_c;

    assign addr_full_c  = {addr_q, DIN};
    assign wdata_full_c = {shd_q, DIN};

    // Address decode; scanning downwards lets the lowest matching index win.
    always_comb begin
        dec_hit_c = 1'b0;
        dec_ro_c  = 1'b0;
        dec_idx_c = '0;
        for (int i = N_REG - 1; i >= 0; i--) begin
            if (REG_ADDRS[i*ADDR_WIDTH +: ADDR_WIDTH] == addr_full_c) begin
                dec_hit_c = 1'b1;
                dec_ro_c  = RO_MASK[i];
                dec_idx_c = IDX_W'(i);
            end
        end
    end

    // Read data mux; unmapped addresses read as zero.
    always_comb begin
        rd_data_c = '0;
        for (int i = 0; i < N_REG; i++) begin
            if (dec_hit_c && (dec_idx_c == IDX_W'(i))) begin
                rd_data_c = REGS[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Transaction FSM, shift registers and register storage.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            op_wr  <= 1'b0;
            cnt    <= '0;
            addr_q <= '0;
            shd_q  <= '0;
            sh_q   <= '0;
            hit_q  <= 1'b0;
            ro_q   <= 1'b0;
            idx_q  <= '0;
            DOUT   <= 1'b0;
            BUSY   <= 1'b0;
            ACK    <= 1'b0;
            ERR    <= 1'b0;
            REGS   <= RST_VALS;
        end else begin
            ACK <= 1'b0;
            ERR <= 1'b0;
            case (state)
                IDLE: begin
                    DOUT <= 1'b0;
                    if (WR_EN && RD_EN) begin
                        ERR <= 1'b1;
                    end else if (WR_EN || RD_EN) begin
                        state <= ADDR;
                        op_wr <= WR_EN;
                        BUSY  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                ADDR: begin
                    addr_q <= addr_full_c[ADDR_WIDTH-2:0];
                    if (cnt == CNT_W'(ADDR_WIDTH - 1)) begin
                        cnt   <= '0;
                        hit_q <= dec_hit_c;
                        ro_q  <= dec_ro_c;
                        idx_q <= dec_idx_c;
                        if (op_wr) begin
                            state <= WDATA;
                        end else begin
                            state <= RDATA;
                            DOUT  <= rd_data_c[DATA_WIDTH-1];
                            sh_q  <= rd_data_c[DATA_WIDTH-2:0];
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WDATA: begin
                    shd_q <= wdata_full_c[DATA_WIDTH-2:0];
                    if (cnt == CNT_W'(DATA_WIDTH - 1)) begin
                        state <= IDLE;
                        cnt   <= '0;
                        BUSY  <= 1'b0;
                        ACK   <= 1'b1;
                        if (hit_q && !ro_q) begin
                            for (int i = 0; i < N_REG; i++) begin
                                if (!RO_MASK[i] && (idx_q == IDX_W'(i))) begin
                                    REGS[i*DATA_WIDTH +: DATA_WIDTH] <= wdata_full_c;
                                end
                            end
                        end else begin
                            ERR <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RDATA: begin
                    DOUT <= sh_q[DATA_WIDTH-2];
                    sh_q <= sh_q << 1;
                    if (cnt == CNT_W'(DATA_WIDTH - 1)) begin
                        state <= IDLE;
                        cnt   <= '0;
                        DOUT  <= 1'b0;
                        BUSY  <= 1'b0;
                        ACK   <= 1'b1;
                        ERR   <= !hit_q;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ser_reg_file_p.sv
// Directed bench for ser_reg_file_p with default parameters.
// Register map: reg0=0x34, reg1=0x78, reg2=0xA1, reg3=0x06, reg4=0x55 (RO, 0x33).
module tb_ser_reg_file_p;

    logic        CLK = 1'b0;
    logic        RST;
    logic        WR_EN;
    logic        RD_EN;
    logic        DIN;
    logic        DOUT;
    logic        BUSY;
    logic        ACK;
    logic        ERR;
    logic [39:0] REGS;

    int          total = 0;
    int          bad   = 0;
    logic [39:0] model;

    localparam logic [39:0] RST_REGS = 40'h33_00_00_00_00;

    always #5 CLK = ~CLK;

    ser_reg_file_p dut (
        .CLK   (CLK),
        .RST   (RST),
        .WR_EN (WR_EN),
        .RD_EN (RD_EN),
        .DIN   (DIN),
        .DOUT  (DOUT),
        .BUSY  (BUSY),
        .ACK   (ACK),
        .ERR   (ERR),
        .REGS  (REGS)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge; outputs then show the new cycle.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // One full transaction; cycle 0 is the strobe cycle, ACK expected in cycle 17.
    // rst_at >= 0 asserts RST during that cycle and ends the transaction early.
    task automatic txn(input bit wr, input logic [7:0] a, input logic [7:0] d,
                       input logic exp_err, input logic [7:0] exp_rd,
                       input logic [39:0] regs_after, input bit noise, input int rst_at);
        for (int c = 0; c <= 17; c++) begin
            WR_EN = 1'b0;
            RD_EN = 1'b0;
            DIN   = 1'b0;
            if (rst_at >= 0 && c == rst_at + 1) begin
                RST = 1'b0;
                check("rst_busy", BUSY, 1'b0);
                check("rst_ack", ACK, 1'b0);
                check("rst_regs", REGS, RST_REGS);
                model = RST_REGS;
                return;
            end
            if (c == 0) begin
                WR_EN = wr;
                RD_EN = !wr;
                check("idle_busy", BUSY, 1'b0);
            end else if (c <= 8) begin
                DIN = a[8-c];
            end else if (c <= 16) begin
                DIN = wr ? d[16-c] : 1'b0;
            end
            if (noise && c == 3)  WR_EN = 1'b1;
            if (noise && c == 11) RD_EN = 1'b1;
            if (c >= 1 && c <= 16) begin
                check("busy", BUSY, 1'b1);
                check("ack_early", ACK, 1'b0);
            end
            if (c >= 9 && c <= 16 && !wr) check("dout", DOUT, exp_rd[16-c]);
            if (c == 16) check("regs_pre", REGS, model);
            if (rst_at == c) RST = 1'b1;
            if (c == 17) begin
                check("ack", ACK, 1'b1);
                check("err", ERR, exp_err);
                check("busy_end", BUSY, 1'b0);
                check("dout_end", DOUT, 1'b0);
                check("regs_post", REGS, regs_after);
                model = regs_after;
            end else begin
                step();
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        RST   = 1'b1;
        WR_EN = 1'b0;
        RD_EN = 1'b0;
        DIN   = 1'b0;
        model = RST_REGS;
        step();
        step();
        RST = 1'b0;
        check("rst_regs0", REGS, RST_REGS);
        check("rst_dout", DOUT, 1'b0);
        check("rst_busy0", BUSY, 1'b0);
        check("rst_ack0", ACK, 1'b0);
        check("rst_err0", ERR, 1'b0);
        step();

        // Write 0xC5 to reg1, then read it back and read the RO reg.
        txn(1'b1, 8'h78, 8'hC5, 1'b0, 8'h00, 40'h33_00_00_C5_00, 1'b0, -1);
        txn(1'b0, 8'h78, 8'h00, 1'b0, 8'hC5, 40'h33_00_00_C5_00, 1'b0, -1);
        txn(1'b0, 8'h55, 8'h00, 1'b0, 8'h33, 40'h33_00_00_C5_00, 1'b0, -1);
        // RO write, unmapped write and unmapped read all flag ERR.
        txn(1'b1, 8'h55, 8'hFF, 1'b1, 8'h00, 40'h33_00_00_C5_00, 1'b0, -1);
        txn(1'b1, 8'h00, 8'hAA, 1'b1, 8'h00, 40'h33_00_00_C5_00, 1'b0, -1);
        txn(1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 40'h33_00_00_C5_00, 1'b0, -1);

        // Both strobes together: ERR alone next cycle, no transaction.
        WR_EN = 1'b1;
        RD_EN = 1'b1;
        step();
        WR_EN = 1'b0;
        RD_EN = 1'b0;
        check("dual_err", ERR, 1'b1);
        check("dual_ack", ACK, 1'b0);
        check("dual_busy", BUSY, 1'b0);
        step();
        check("dual_err_clr", ERR, 1'b0);
        check("dual_busy2", BUSY, 1'b0);

        // Strobes mid-transaction are ignored.
        txn(1'b1, 8'hA1, 8'h3C, 1'b0, 8'h00, 40'h33_00_3C_C5_00, 1'b1, -1);

        // Reset in cycle 12 of a write drops it; next write works.
        txn(1'b1, 8'h34, 8'h77, 1'b0, 8'h00, RST_REGS, 1'b0, 12);
        txn(1'b1, 8'h34, 8'h5A, 1'b0, 8'h00, 40'h33_00_00_00_5A, 1'b0, -1);
        txn(1'b0, 8'h34, 8'h00, 1'b0, 8'h5A, 40'h33_00_00_00_5A, 1'b0, -1);

        step();
        check("final_ack", ACK, 1'b0);
        check("final_busy", BUSY, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ser_reg_file_p.md
Name: ser_reg_file_p

Overview:
Parametrised serial-access register file, the successor to the fixed 5-register serial write block. A host issues one-cycle WR_EN/RD_EN strobes, then shifts address and data bits on DIN, MSB first. Write data is collected in a shadow register and committed atomically. Reads return data serially on DOUT. Per-register address, reset value and read-only attribute are set by parameters, and completion and error are signalled per transaction.

Parameters:
N_REG, 5, number of registers (1..16)
ADDR_WIDTH, 8, serial address width in bits (>=2)
DATA_WIDTH, 8, register width in bits (>=2)
REG_ADDRS, {8'h55,8'h06,8'hA1,8'h78,8'h34}, N_REG*ADDR_WIDTH packed vector; slice i = address of reg i (reg 0 in LSBs)
RST_VALS, {8'h33,8'h00,8'h00,8'h00,8'h00}, N_REG*DATA_WIDTH packed reset/constant values; slice i = reg i
RO_MASK, 5'b10000, bit i = 1 makes reg i read-only (holds RST_VALS slice forever)

Ports:
CLK  in  1  clock; all logic on rising edge
RST  in  1  synchronous reset, active-high
WR_EN  in  1  write-transaction start strobe, sampled in IDLE only
RD_EN  in  1  read-transaction start strobe, sampled in IDLE only
DIN  in  1  serial address/write-data input, MSB first
DOUT  out  1  serial read-data output, MSB first
BUSY  out  1  high while a transaction is in progress
ACK  out  1  one-cycle pulse: transaction finished
ERR  out  1  one-cycle pulse coincident with ACK or protocol error (see below)
REGS  out  N_REG*DATA_WIDTH  parallel view of all register contents, reg i in slice i

Behaviour:
- Reset (RST=1 at an edge): FSM -> IDLE; reg i <= RST_VALS slice i; address, shadow and output shift regs cleared; DOUT=BUSY=ACK=ERR=0. Reset applies mid-transaction too: the partial transaction is dropped with no commit and no ACK.
- FSM states: IDLE, ADDR, WDATA, RDATA. The bit counter is ceil(log2(max(ADDR_WIDTH,DATA_WIDTH)))+1 bits wide and is cleared on each state entry.
- IDLE (BUSY=0):
  - WR_EN=1, RD_EN=0 -> ADDR with op=write.
  - RD_EN=1, WR_EN=0 -> ADDR with op=read.
  - WR_EN=1 and RD_EN=1 -> stay IDLE; ERR pulses alone in the next cycle (no ACK).
  - DIN is not sampled in the strobe cycle.
- ADDR (BUSY=1): shift DIN into the address reg for ADDR_WIDTH cycles. On the last bit, decode the full address as {addr[ADDR_WIDTH-2:0],DIN}.
  - op=write -> WDATA.
  - op=read -> RDATA. In the same edge, load the output shift reg with the matched register, or all-zeros if unmapped.
- Decode: the lowest index i whose REG_ADDRS slice equals the address wins (duplicate addresses resolve to the lowest index).
- WDATA (BUSY=1): shift DIN into the shadow reg for DATA_WIDTH cycles; registers are untouched meanwhile.
  - At the edge sampling the last bit, commit {shadow[DATA_WIDTH-2:0],DIN} to the matched reg if it is mapped and not RO, then -> IDLE.
  - Otherwise discard the data and flag an error.
- RDATA (BUSY=1): DOUT = output shift reg MSB for exactly DATA_WIDTH cycles, shifting left each edge. After the last bit -> IDLE. DOUT=0 in all other states.
- Timing: with strobe in cycle 0, address bits occupy cycles 1..ADDR_WIDTH and data bits cycles ADDR_WIDTH+1..ADDR_WIDTH+DATA_WIDTH. In cycle ADDR_WIDTH+DATA_WIDTH+1: ACK=1, BUSY=0, state IDLE. REGS shows a new write value from that same cycle. A new strobe is accepted in that cycle.
- ERR with ACK: unmapped address (read or write), or write to an RO reg. A read of an RO reg is legal.
- WR_EN/RD_EN while BUSY are ignored with no effect.
- REGS is driven directly from the register flops. RO regs are constants equal to RST_VALS.

Test Plan:
- Reset, then idle -> REGS = {8'h33,8'h00,8'h00,8'h00,8'h00}; DOUT/BUSY/ACK/ERR = 0.
- Write addr 8'h78, data 8'hC5 -> reg 1 = 8'hC5 only in cycle 17 (unchanged through cycle 16); ACK=1, ERR=0 in cycle 17.
- Read addr 8'h78 after the above -> DOUT over cycles 9..16 = 1,1,0,0,0,1,0,1; ACK in cycle 17. Read addr 8'h55 -> 8'h33 serialised, ERR=0.
- Write 8'hFF to addr 8'h55 (RO), then write 8'hAA to unmapped addr 8'h00 -> no REGS change; each transaction has ACK+ERR in cycle 17. Read 8'h00 -> DOUT all 0 with ERR.
- WR_EN+RD_EN together in IDLE -> ERR alone next cycle, BUSY stays 0. Strobes pulsed mid-transaction -> ignored, original transaction completes normally.
- Assert RST at cycle 12 of a write to 8'h34 -> reg 0 stays 8'h00, no ACK. A new write accepted right after reset completes correctly.
